// File: rtl/keypad_debounce.sv
// Keypad conditioner: synchronises 16 key lines, debounces press/release, encodes the key, and emits one shift pulse per press.
// Optional auto-repeat while a key is held is compiled in with `define KEYPAD_REPEAT_EN.
`timescale 1ns/1ps
module keypad_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys,
    output logic [3:0]  button,
    output logic        shift,
    output logic        pressed
);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} state_t;

    logic [15:0] sync1_q;
    logic [15:0] ks_q;
    state_t      state_q;
    logic [3:0]  cand_q;
    logic [15:0] cnt_q;
    logic [3:0]  button_q;
    logic        shift_q;

    logic        ks_none;
    logic        ks_single;
    logic [3:0]  ks_idx;
    logic        cand_match;
    logic        cnt_done;
    logic [15:0] cnt_d;
    logic        rpt_fire;

    assign ks_none    = (ks_q == 16'd0);
    assign ks_single  = !ks_none && ((ks_q & (ks_q - 16'd1)) == 16'd0);
    assign cand_match = (ks_q == (16'd1 << cand_q));
    assign cnt_done   = (cnt_q == DEBOUNCE_CYCLES - 16'd1);
    assign cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        ks_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (ks_q[i]) ks_idx = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 16'd0;
            ks_q    <= 16'd0;
        end else begin
            sync1_q <= keys;
            ks_q    <= sync1_q;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [23:0] rpt_q;

    assign rpt_fire = (state_q == HELD) && cand_match && (rpt_q == REPEAT_CYCLES - 24'd1);

    // Counter only runs in HELD, so it is already zero on every entry to HELD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= 24'd0;
        end else if (state_q != HELD || !cand_match || rpt_fire) begin
            rpt_q <= 24'd0;
        end else begin
            rpt_q <= rpt_q + 24'd1;
        end
    end
`else
    logic unused_rpt;

    assign rpt_fire   = 1'b0;
    assign unused_rpt = ^REPEAT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= 4'd0;
            cnt_q    <= 16'd0;
            button_q <= 4'd0;
            shift_q  <= 1'b0;
        end else begin
            shift_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ks_single) begin
                        cand_q  <= ks_idx;
                        cnt_q   <= 16'd0;
                        state_q <= PRESS;
                    end
                end
                PRESS: begin
                    if (!cand_match) begin
                        cnt_q   <= 16'd0;
                        state_q <= IDLE;
                    end else if (cnt_done) begin
                        button_q <= cand_q;
                        shift_q  <= 1'b1;
                        state_q  <= HELD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HELD: begin
                    if (ks_none) begin
                        cnt_q   <= 16'd0;
                        state_q <= REL;
                    end else if (rpt_fire) begin
                        shift_q <= 1'b1;
                    end
                end
                REL: begin
                    // Any activity during release is bounce: back to HELD without a new digit.
                    if (!ks_none) begin
                        state_q <= HELD;
                    end else if (cnt_done) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign button  = button_q;
    assign shift   = shift_q;
    assign pressed = (state_q == HELD) || (state_q == REL);

endmodule

// File: tb/tb_keypad_debounce.sv
// Scoreboard bench for keypad_debounce with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10; directed key sequences.
`timescale 1ns/1ps
module tb_keypad_debounce;

    typedef struct {
        logic [3:0] btn;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'd0;
    logic [3:0]  button;
    logic        shift;
    logic        pressed;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    keypad_debounce #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_CYCLES  (24'd10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .keys   (keys),
        .button (button),
        .shift  (shift),
        .pressed(pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] k, output int e0);
        @(negedge clk);
        keys = k;
        e0 = cyc + 1;
    endtask

    // Monitor: every shift pulse must match the next expected (button, cycle).
    always @(negedge clk) begin
        if (!rst && shift === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_shift: got pulse with button %0d expected none (cycle %0d)", button, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("shift_button", int'(button), int'(e.btn));
                check("shift_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int f;
        int n;

        repeat (3) @(negedge clk);
        check("reset_button", int'(button), 0);
        check("reset_shift", int'(shift), 0);
        check("reset_pressed", int'(pressed), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press of key 5, then clean release.
        drive(16'h0020, e0);
        sb.push_back('{4'h5, e0 + 6});
        wait_cyc(e0 + 5);
        check("press_pressed_before", int'(pressed), 0);
        wait_cyc(e0 + 6);
        check("press_pressed_at", int'(pressed), 1);
        wait_cyc(e0 + 12);
        check("press_pressed_held", int'(pressed), 1);
        drive(16'h0000, e0);
        wait_cyc(e0 + 5);
        check("release_pressed_rel", int'(pressed), 1);
        wait_cyc(e0 + 6);
        check("release_pressed_idle", int'(pressed), 0);

        // Press bounce: 3 cycles on, 1 off, five times, then a stable hold on key 3.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0008;
            repeat (3) @(negedge clk);
            keys = 16'h0000;
            @(negedge clk);
        end
        check("bounce_button_held", int'(button), 5);
        check("bounce_pressed", int'(pressed), 0);
        keys = 16'h0008;
        e0 = cyc + 1;
        sb.push_back('{4'h3, e0 + 6});
        wait_cyc(e0 + 8);
        drive(16'h0000, e0);
        wait_cyc(e0 + 10);

        // Two keys at once are never accepted.
        drive(16'h0011, e0);
        wait_cyc(e0 + 20);
        check("multi_pressed", int'(pressed), 0);
        check("multi_button", int'(button), 3);
        drive(16'h0000, e0);
        wait_cyc(e0 + 6);

        // Release bounce on key A.
        drive(16'h0400, e0);
        sb.push_back('{4'hA, e0 + 6});
        wait_cyc(e0 + 10);
        keys = 16'h0000;     repeat (2) @(negedge clk);
        keys = 16'h0400;     repeat (2) @(negedge clk);
        keys = 16'h0000;     repeat (2) @(negedge clk);
        keys = 16'h0400;     repeat (2) @(negedge clk);
        check("relbounce_pressed_mid", int'(pressed), 1);
        keys = 16'h0000;
        f = cyc + 1;
        wait_cyc(f + 5);
        check("relbounce_pressed_rel", int'(pressed), 1);
        wait_cyc(f + 6);
        check("relbounce_pressed_idle", int'(pressed), 0);
        check("relbounce_button", int'(button), 10);

        // Long hold of key 1: one pulse, plus repeats every 10 cycles when compiled in.
        drive(16'h0002, e0);
        sb.push_back('{4'h1, e0 + 6});
`ifdef KEYPAD_REPEAT_EN
        for (int k = 1; k <= 4; k++) sb.push_back('{4'h1, e0 + 6 + 10 * k});
`endif
        wait_cyc(e0 + 46);
        keys = 16'h0000;
        wait_cyc(e0 + 58);
        check("hold_pressed_after", int'(pressed), 0);

        // Asynchronous reset in the middle of a press debounce (cnt=2).
        drive(16'h0080, e0);
        wait_cyc(e0 + 4);
        #2 rst = 1'b1;
        #1;
        check("midrst_button", int'(button), 0);
        check("midrst_shift", int'(shift), 0);
        check("midrst_pressed", int'(pressed), 0);
        @(negedge clk);
        rst = 1'b0;
        n = cyc;
        sb.push_back('{4'h7, n + 7});
        wait_cyc(n + 6);
        check("midrst_no_early_pulse", int'(button), 0);
        wait_cyc(n + 10);
        check("midrst_pressed_after", int'(pressed), 1);
        drive(16'h0000, e0);
        wait_cyc(e0 + 10);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
